mnist_tile_scheduler: RTL and testbench
=======================================

// Module: mnist_tile_scheduler
// PURPOSE
// Sequences one MNIST inference (1xARRAY_A_L activations times ARRAY_A_L x ARRAY_W_L weights) on the shared systolic array.
// Splits K into TILE_K-wide tiles and issues one array job per tile.
// Accumulates the partial sums, then runs a sequential signed argmax to drive the one-hot classes and hex digit.
// Sits between the board buttons/switches and the systolic-array wrapper.
// PARAMETERS
// DATA_WIDTH  16   operand width; sets ACC_WIDTH default
// ARRAY_A_L   784  activation length (K); multiple of TILE_K
// ARRAY_W_L   10   output classes (N)
// TILE_K      16   K elements per array job; NUM_TILES = ARRAY_A_L/TILE_K = 49
// ACC_WIDTH   42   signed accumulator width (2*DATA_WIDTH + clog2(ARRAY_A_L))
// IMAGES      10   images stored in activation memory
// TIMEOUT     1024 max cycles waiting for sa_valid per tile
// PORTS
// clk         in   1                  system clock
// reset_n     in   1                  async active-low reset
// start_comp  in   1                  active-low button; falling edge = start request
// image_num   in   4                  image index, latched on accepted start
// act_addr    out  clog2(IMAGES*ARRAY_A_L)  activation tile base word address
// w_addr      out  clog2(ARRAY_A_L)   weight tile base row (tile*TILE_K)
// sa_start    out  1                  1-cycle job strobe; addresses valid that cycle
// sa_valid    in   1                  job result valid (1-cycle pulse)
// sa_result   in   ARRAY_W_L*ACC_WIDTH  signed partial sums; class i at [i*ACC_WIDTH +: ACC_WIDTH]
// ready       out  1                  result valid; held until next accepted start
// error       out  1                  bad image_num or timeout on last run
// classes     out  ARRAY_W_L          one-hot winning class
// class_idx   out  4                  winning index for hex decoder; 4'hF on error
// BEHAVIOUR
// - Reset (async): state IDLE; ready=0, error=0, classes=0, class_idx=0, sa_start=0, addrs=0; accumulators=0.
// - start_comp is registered twice. Start event = prev 1 and current 0.
// - Start is accepted only in IDLE or DONE; it is ignored while busy.
// - Accept: ready<=0, error<=0, latch image_num, clear accumulators, tile<=0.
// - Accept with image_num >= IMAGES: go straight to DONE with error=1, classes=0, class_idx=F.
// - ISSUE (1 cycle): sa_start=1; act_addr=img*ARRAY_A_L+tile*TILE_K; w_addr=tile*TILE_K.
// - WAIT: count cycles. On sa_valid, register sa_result and go to ACCUM.
// - WAIT timeout: count reaching TIMEOUT goes to DONE with error=1, classes=0, class_idx=F.
// - sa_valid outside WAIT is ignored.
// - ACCUM (1 cycle): acc[i] += part[i], wrapping modulo 2^ACC_WIDTH.
// - ACCUM exit: tile==NUM_TILES-1 -> ARGMAX, else tile++ -> ISSUE.
// - ARGMAX: ARRAY_W_L cycles, one class per cycle, signed strict-greater compare. Ties go to the lowest index; best starts at acc[0].
// - DONE: classes=1<<best, class_idx=best, ready=1; outputs hold until the next accepted start.
// - Latency: with array latency L (sa_start to sa_valid), start edge to ready = 2 (sync) + NUM_TILES*(L+2) + ARRAY_W_L + 1 cycles.
// - Reset mid-run aborts immediately. No sa_start is issued after reset deasserts until a new start event.
// STRUCTURE
// - Package mnist_sched_pkg holds:
//   - state enum {IDLE, ISSUE, WAIT, ACCUM, ARGMAX, DONE};
//   - NUM_TILES, TILE_CNT_W, ADDR widths, TO_CNT_W as localparam functions of the parameters.
// - Sub-module mnist_argmax_seq: sequential argmax.
//   - Inputs: start, ARRAY_W_L x ACC_WIDTH vector.
//   - Outputs: done, idx.
// - The top holds the FSM, address generation, accumulators and timeout counter.
// TESTING
// - Mock array with L=3.
// 1. Reset values: hold reset_n=0 -> all outputs 0. Release with no start -> sa_start never asserted.
// 2. image 3, class 7 gets +1 per tile, others 0:
//    - act_addr sequence 2352,2368,...,3120; w_addr 0..768 step 16; 49 sa_start pulses;
//    - acc[7]=49; classes=10'b0010000000, class_idx=7, ready=1 after 2+49*5+10+1 cycles.
// 3. Tie and sign cases:
//    - classes 2 and 5 both get +3/tile -> class_idx=2;
//    - all classes negative, class 9 least negative (-1/tile) -> class_idx=9.
// 4. Bad image and timeout:
//    - image_num=12 -> no sa_start; ready=1, error=1, classes=0, class_idx=F;
//    - mock withholds sa_valid on tile 5 -> error=1 after TIMEOUT cycles.
// 5. Start while busy and reset mid-run:
//    - second start_comp falling edge mid-run is ignored; exactly 49 jobs issued;
//    - reset_n pulsed low at tile 20 -> all outputs 0, FSM in IDLE;
//    - a following start with image 0 completes correctly.
// 6. Back-to-back runs: images 0..9, each started after ready.
//    - classes match a reference model for each image;
//    - error stays 0 for every run.

Source files
------------

// File: rtl/mnist_sched_pkg.sv
// Shared state type and derived-size helpers for the MNIST tile scheduler.
package mnist_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACCUM,
    ST_ARGMAX,
    ST_DONE
  } sched_state_e;

  // Hex digit shown when a run ends in error.
  localparam logic [3:0] CLASS_IDX_ERR = 4'hF;

  // Index width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int f_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int f_num_tiles(input int a_l, input int tile_k);
    return a_l / tile_k;
  endfunction

  function automatic int f_tile_cnt_w(input int a_l, input int tile_k);
    return f_clog2_min1(f_num_tiles(a_l, tile_k));
  endfunction

  function automatic int f_act_addr_w(input int images, input int a_l);
    return f_clog2_min1(images * a_l);
  endfunction

  function automatic int f_w_addr_w(input int a_l);
    return f_clog2_min1(a_l);
  endfunction

  // The timeout counter is loaded with TIMEOUT-1 and counts down to zero.
  function automatic int f_to_cnt_w(input int timeout);
    return f_clog2_min1(timeout);
  endfunction

endpackage

// File: rtl/mnist_argmax_seq.sv
// Sequential signed argmax: inspects one class per cycle, ties keep the lower index.
// done_o and idx_o are valid together in the cycle the last class is inspected.
module mnist_argmax_seq
  import mnist_sched_pkg::*;
#(
  parameter int N     = 10,
  parameter int W     = 42,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [N*W-1:0]   vec_i,
  output logic             done_o,
  output logic [IDX_W-1:0] idx_o
);

  logic                busy_q;
  logic [IDX_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic signed [W-1:0] best_q;
  logic signed [W-1:0] cur;
  logic                take;
  logic                last;

  // Select the class under inspection and decide whether it replaces the running best.
  always_comb begin
    cur    = vec_i[int'(cnt_q)*W +: W];
    last   = (cnt_q == IDX_W'(N - 1));
    take   = (cnt_q == '0) || (cur > best_q);
    done_o = busy_q && last;
    idx_o  = take ? cnt_q : best_idx_q;
  end

  // Walk the classes once per start; the first class seeds the running best.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      if (take) begin
        best_q     <= cur;
        best_idx_q <= cnt_q;
      end
      if (last) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mnist_tile_scheduler.sv
// Sequences one MNIST inference on the shared systolic array: one job per K tile,
// accumulates the partial sums, then runs a sequential argmax for the result.
//
// state     | meaning
// ST_IDLE   | waiting for the first start after reset
// ST_ISSUE  | one-cycle sa_start strobe with the tile addresses
// ST_WAIT   | waiting for sa_valid, timeout counter running
// ST_ACCUM  | add the registered partial sums into the accumulators
// ST_ARGMAX | one class per cycle through mnist_argmax_seq
// ST_DONE   | result (or error) held until the next accepted start
module mnist_tile_scheduler
  import mnist_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ARRAY_A_L   = 784,
  parameter int ARRAY_W_L   = 10,
  parameter int TILE_K      = 16,
  parameter int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(ARRAY_A_L),
  parameter int IMAGES      = 10,
  parameter int TIMEOUT     = 1024,
  localparam int NUM_TILES  = f_num_tiles(ARRAY_A_L, TILE_K),
  localparam int TILE_CNT_W = f_tile_cnt_w(ARRAY_A_L, TILE_K),
  localparam int ACT_AW     = f_act_addr_w(IMAGES, ARRAY_A_L),
  localparam int W_AW       = f_w_addr_w(ARRAY_A_L),
  localparam int TO_CNT_W   = f_to_cnt_w(TIMEOUT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start_comp,
  input  logic [3:0]                     image_num,
  output logic [ACT_AW-1:0]              act_addr,
  output logic [W_AW-1:0]                w_addr,
  output logic                           sa_start,
  input  logic                           sa_valid,
  input  logic [ARRAY_W_L*ACC_WIDTH-1:0] sa_result,
  output logic                           ready,
  output logic                           error,
  output logic [ARRAY_W_L-1:0]           classes,
  output logic [3:0]                     class_idx
);

  localparam int IDX_W = 4;
  localparam logic [ACT_AW-1:0] IMG_STRIDE  = ACT_AW'(ARRAY_A_L);
  localparam logic [ACT_AW-1:0] ACT_STEP    = ACT_AW'(TILE_K);
  localparam logic [W_AW-1:0]   W_STEP      = W_AW'(TILE_K);
  localparam logic [TO_CNT_W-1:0] TO_LOAD   = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [TILE_CNT_W-1:0] TILE_LAST = TILE_CNT_W'(NUM_TILES - 1);

  sched_state_e state_q, state_d;

  logic btn_meta_q, btn_sync_q, btn_prev_q;
  logic start_evt, accept, img_bad, last_tile, timeout_hit, argmax_fin;

  logic [TILE_CNT_W-1:0] tile_q;
  logic [TO_CNT_W-1:0]   to_cnt_q;
  logic [ACT_AW-1:0]     act_addr_q;
  logic [W_AW-1:0]       w_addr_q;

  logic [ARRAY_W_L-1:0][ACC_WIDTH-1:0] part_q;
  logic [ARRAY_W_L-1:0][ACC_WIDTH-1:0] acc_q;

  logic                 ready_q, error_q;
  logic [ARRAY_W_L-1:0] classes_q;
  logic [3:0]           class_idx_q;

  logic             am_start, am_done;
  logic [IDX_W-1:0] am_idx;

  // Button synchroniser; idle level is high so reset release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      btn_prev_q <= 1'b1;
    end else begin
      btn_meta_q <= start_comp;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign start_evt   = btn_prev_q && !btn_sync_q;
  assign accept      = start_evt && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign img_bad     = (int'(image_num) >= IMAGES);
  assign last_tile   = (tile_q == TILE_LAST);
  assign timeout_hit = (state_q == ST_WAIT) && !sa_valid && (to_cnt_q == '0);
  assign argmax_fin  = (state_q == ST_ARGMAX) && am_done;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = img_bad ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sa_valid) begin
          state_d = ST_ACCUM;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_ACCUM:  state_d = last_tile ? ST_ARGMAX : ST_ISSUE;
      ST_ARGMAX: begin
        if (am_done) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: job strobe and argmax kick-off on the last accumulate.
  always_comb begin
    sa_start = 1'b0;
    am_start = 1'b0;
    case (state_q)
      ST_ISSUE: sa_start = 1'b1;
      ST_ACCUM: am_start = last_tile;
      default: ;
    endcase
  end

  // Tile index, address generation and per-tile timeout down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_q     <= '0;
      to_cnt_q   <= '0;
      act_addr_q <= '0;
      w_addr_q   <= '0;
    end else if (accept) begin
      tile_q <= '0;
      if (!img_bad) begin
        act_addr_q <= ACT_AW'(image_num) * IMG_STRIDE;
        w_addr_q   <= '0;
      end
    end else begin
      case (state_q)
        ST_ISSUE: to_cnt_q <= TO_LOAD;
        ST_WAIT: begin
          if (!sa_valid && (to_cnt_q != '0)) begin
            to_cnt_q <= to_cnt_q - TO_CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (!last_tile) begin
            tile_q     <= tile_q + TILE_CNT_W'(1);
            act_addr_q <= act_addr_q + ACT_STEP;
            w_addr_q   <= w_addr_q + W_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // Partial-sum capture and wrapping accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      part_q <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if ((state_q == ST_WAIT) && sa_valid) begin
      part_q <= sa_result;
    end else if (state_q == ST_ACCUM) begin
      for (int i = 0; i < ARRAY_W_L; i++) begin
        acc_q[i] <= acc_q[i] + part_q[i];
      end
    end
  end

  // Result and status registers; held between runs, cleared by a good start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      classes_q   <= '0;
      class_idx_q <= '0;
    end else if (accept) begin
      ready_q <= img_bad;
      error_q <= img_bad;
      if (img_bad) begin
        classes_q   <= '0;
        class_idx_q <= CLASS_IDX_ERR;
      end
    end else if (timeout_hit) begin
      ready_q     <= 1'b1;
      error_q     <= 1'b1;
      classes_q   <= '0;
      class_idx_q <= CLASS_IDX_ERR;
    end else if (argmax_fin) begin
      ready_q     <= 1'b1;
      classes_q   <= ARRAY_W_L'(1) << am_idx;
      class_idx_q <= am_idx;
    end
  end

  mnist_argmax_seq #(
    .N     (ARRAY_W_L),
    .W     (ACC_WIDTH),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (reset_n),
    .start_i (am_start),
    .vec_i   (acc_q),
    .done_o  (am_done),
    .idx_o   (am_idx)
  );

  assign act_addr  = act_addr_q;
  assign w_addr    = w_addr_q;
  assign ready     = ready_q;
  assign error     = error_q;
  assign classes   = classes_q;
  assign class_idx = class_idx_q;

endmodule

// File: tb/tb_mnist_tile_scheduler.sv
// Self-checking bench: mock systolic array (latency 3) plus a sum-and-argmax reference model.
module tb_mnist_tile_scheduler;

  localparam int AL   = 784;
  localparam int WL   = 10;
  localparam int TK   = 16;
  localparam int NT   = AL / TK;
  localparam int ACCW = 42;
  localparam int IMG  = 10;
  localparam int TO   = 1024;
  localparam int LAT  = 3;
  localparam int RUN_LAT = 2 + NT * (LAT + 2) + WL + 1;
  localparam int TO_LAT  = 2 + 5 * (LAT + 2) + 1 + TO;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              start_comp = 1'b1;
  logic [3:0]        image_num  = 4'd0;
  logic [12:0]       act_addr;
  logic [9:0]        w_addr;
  logic              sa_start;
  logic              sa_valid   = 1'b0;
  logic [WL*ACCW-1:0] sa_result = '0;
  logic              ready, error;
  logic [WL-1:0]     classes;
  logic [3:0]        class_idx;

  mnist_tile_scheduler #(
    .DATA_WIDTH (16),
    .ARRAY_A_L  (AL),
    .ARRAY_W_L  (WL),
    .TILE_K     (TK),
    .ACC_WIDTH  (ACCW),
    .IMAGES     (IMG),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_comp (start_comp),
    .image_num  (image_num),
    .act_addr   (act_addr),
    .w_addr     (w_addr),
    .sa_start   (sa_start),
    .sa_valid   (sa_valid),
    .sa_result  (sa_result),
    .ready      (ready),
    .error      (error),
    .classes    (classes),
    .class_idx  (class_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Mock array state and per-run stimulus table.
  int     pend      = 0;
  int     job_n     = 0;
  int     rsp_tile  = 0;
  int     cur_img   = 0;
  int     hold_tile = -1;
  bit     chk_addr  = 1'b0;
  longint part_tbl[NT][WL];
  longint mk_v;

  // Mock array: answers each sa_start with one sa_valid pulse LAT cycles later.
  always @(negedge clk) begin
    sa_valid = 1'b0;
    if (!reset_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0 && rsp_tile != hold_tile) begin
          for (int i = 0; i < WL; i++) begin
            mk_v = part_tbl[rsp_tile][i];
            sa_result[i*ACCW +: ACCW] = mk_v[ACCW-1:0];
          end
          sa_valid = 1'b1;
        end
      end
      if (sa_start) begin
        if (chk_addr) begin
          chk("act_addr", act_addr, cur_img * AL + job_n * TK);
          chk("w_addr", w_addr, job_n * TK);
        end
        rsp_tile = job_n % NT;
        pend     = LAT;
        job_n++;
      end
    end
  end

  task automatic set_pattern(input int mode);
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < WL; i++) begin
        case (mode)
          0: part_tbl[t][i] = (i == 7) ? 1 : 0;
          1: part_tbl[t][i] = (i == 2 || i == 5) ? 3 : 0;
          2: part_tbl[t][i] = (i == 9) ? -1 : -longint'($urandom_range(5, 2));
          3: part_tbl[t][i] = longint'($urandom_range(2000000, 0)) - 1000000;
          default: part_tbl[t][i] = (longint'($urandom) <<< 8) - (longint'(1) <<< 39);
        endcase
      end
    end
  endtask

  // Reference: wrapped per-class sums, first strictly greatest wins.
  function automatic int ref_best();
    longint s[WL];
    longint m;
    int     b;
    for (int i = 0; i < WL; i++) begin
      s[i] = 0;
      for (int t = 0; t < NT; t++) s[i] += part_tbl[t][i];
      m = s[i] & ((longint'(1) <<< ACCW) - 1);
      if (m >= (longint'(1) <<< (ACCW - 1))) m -= (longint'(1) <<< ACCW);
      s[i] = m;
    end
    b = 0;
    for (int i = 1; i < WL; i++) if (s[i] > s[b]) b = i;
    return b;
  endfunction

  task automatic run_img(input int img, input bit poke, output int lat, output bit done);
    int n;
    job_n    = 0;
    cur_img  = img;
    chk_addr = 1'b1;
    @(negedge clk);
    image_num  = 4'(img);
    start_comp = 1'b0;
    lat  = cyc;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 3) start_comp = 1'b1;
      if (poke && n == 100) start_comp = 1'b0;
      if (poke && n == 104) start_comp = 1'b1;
      if (n >= 4 && ready) done = 1'b1;
    end
    lat = cyc - lat;
  endtask

  task automatic check_good(input string tag, input int exp_best, input bit done);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_jobs"}, job_n, NT);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_idx"}, class_idx, exp_best);
    chk({tag, "_classes"}, classes, 64'(1) << exp_best);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit done;
    int b;
    int jn;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_classes", classes, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_sa_start", sa_start, 0);
    chk("rst_act_addr", act_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_job", job_n, 0);
    chk("idle_ready", ready, 0);

    set_pattern(0);
    run_img(3, 1'b0, lat, done);
    check_good("c7", 7, done);
    chk("c7_latency", lat, RUN_LAT);
    chk("c7_model", ref_best(), 7);

    set_pattern(1);
    run_img(1, 1'b0, lat, done);
    check_good("tie", 2, done);

    set_pattern(2);
    run_img(6, 1'b0, lat, done);
    check_good("neg", 9, done);

    run_img(12, 1'b0, lat, done);
    chk("bad_done", done, 1);
    chk("bad_jobs", job_n, 0);
    chk("bad_ready", ready, 1);
    chk("bad_error", error, 1);
    chk("bad_classes", classes, 0);
    chk("bad_idx", class_idx, 15);

    set_pattern(3);
    hold_tile = 5;
    run_img(2, 1'b0, lat, done);
    hold_tile = -1;
    chk("to_done", done, 1);
    chk("to_jobs", job_n, 6);
    chk("to_error", error, 1);
    chk("to_classes", classes, 0);
    chk("to_idx", class_idx, 15);
    chk("to_latency_window", (lat >= TO_LAT - 1) && (lat <= TO_LAT + 1), 1);

    set_pattern(3);
    b = ref_best();
    run_img(8, 1'b1, lat, done);
    check_good("busy_start", b, done);

    set_pattern(4);
    job_n    = 0;
    cur_img  = 4;
    chk_addr = 1'b1;
    @(negedge clk);
    image_num  = 4'd4;
    start_comp = 1'b0;
    n = 0;
    while (job_n < 21 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 3) start_comp = 1'b1;
    end
    chk("mid_reached_tile20", job_n >= 21, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_classes", classes, 0);
    chk("mid_rst_idx", class_idx, 0);
    chk("mid_rst_sa_start", sa_start, 0);
    chk("mid_rst_act_addr", act_addr, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    repeat (2) @(negedge clk);
    jn = job_n;
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_no_job", job_n, jn);
    chk("post_rst_ready", ready, 0);

    set_pattern(3);
    b = ref_best();
    run_img(0, 1'b0, lat, done);
    check_good("post_rst_img0", b, done);

    for (int img = 0; img < IMG; img++) begin
      set_pattern((img % 2 == 0) ? 3 : 4);
      b = ref_best();
      run_img(img, 1'b0, lat, done);
      check_good($sformatf("b2b%0d", img), b, done);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
